spi_slave_responder: RTL and testbench

//  Synthesisable SPI slave that sits directly downstream of the SPI master pads: it consumes
//  ss_pad_o/sclk/mosi_pad_o and produces miso_pad_i. Pad inputs are oversampled in the

---
 rtl/spi_slave_responder.sv | 185 ++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// SPI slave with oversampled pad inputs, a one-entry transmit holding buffer and a
// received-word strobe; usable as a loop-back target for an SPI master.
module spi_slave_responder #(
    parameter int DATA_W    = 32,
    parameter int SS_BIT    = 0,
    parameter int LSB_FIRST = 0,
    parameter int RX_NEG    = 0,
    parameter int TX_NEG    = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [7:0]        ss_pad_o,
    input  logic              sclk,
    input  logic              mosi_pad_o,
    output logic              miso_pad_i,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic [7:0]        rx_bits,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [7:0] FULL_CNT = 8'(DATA_W);
    localparam logic [8:0] WIDTH_9  = 9'(DATA_W);

    state_t            state_q, state_d;
    logic              ss_meta, ss_sync;
    logic              sclk_meta, sclk_sync, sclk_prev;
    logic              mosi_meta, mosi_sync;
    logic [DATA_W-1:0] rx_shift, tx_shift, hold_data;
    logic [DATA_W-1:0] rx_shifted, tx_shifted, rx_aligned;
    logic              hold_full, sampled, pending_underrun;
    logic [7:0]        bit_cnt;
    logic [8:0]        align_amt;
    logic              start_frame, end_frame, word_done, reload;
    logic              do_sample, do_drive, report;
    logic              sclk_rise, sclk_fall, sample_edge, drive_edge;
    logic              unused_ss_bits;

    assign unused_ss_bits = ^ss_pad_o;

    // Two-flop synchronizers on every pad, plus a history flop for sclk edge detection.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            ss_meta   <= ss_pad_o[SS_BIT];
            ss_sync   <= ss_meta;
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            mosi_meta <= mosi_pad_o;
            mosi_sync <= mosi_meta;
        end
    end

    assign sclk_rise   = sclk_sync & ~sclk_prev;
    assign sclk_fall   = ~sclk_sync & sclk_prev;
    assign sample_edge = (RX_NEG != 0) ? sclk_fall : sclk_rise;
    assign drive_edge  = (TX_NEG != 0) ? sclk_fall : sclk_rise;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ss_sync) begin
                    state_d     = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_sync) begin
                    state_d   = IDLE;
                    end_frame = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A drive edge only advances miso once the current word has had a sample edge, which
    // covers both the CPHA=0 leading edge and the edge right after a word reload.
    assign word_done  = (state_q == ACTIVE) && (bit_cnt == FULL_CNT);
    assign reload     = start_frame || (word_done && !end_frame);
    assign do_sample  = (state_q == ACTIVE) && !ss_sync && sample_edge && !word_done;
    assign do_drive   = (state_q == ACTIVE) && !ss_sync && drive_edge && sampled && !reload;
    assign report     = word_done || (end_frame && (bit_cnt != 8'd0));

    assign rx_shifted = (LSB_FIRST != 0) ? {mosi_sync, rx_shift[DATA_W-1:1]}
                                         : {rx_shift[DATA_W-2:0], mosi_sync};
    assign tx_shifted = (LSB_FIRST != 0) ? {1'b0, tx_shift[DATA_W-1:1]}
                                         : {tx_shift[DATA_W-2:0], 1'b0};
    assign align_amt  = WIDTH_9 - {1'b0, bit_cnt};
    assign rx_aligned = (LSB_FIRST != 0) ? (rx_shift >> align_amt) : rx_shift;

    assign tx_ready   = !hold_full;
    assign busy       = (state_q == ACTIVE);
    assign miso_pad_i = (state_q == ACTIVE) ? ((LSB_FIRST != 0) ? tx_shift[0] : tx_shift[DATA_W-1])
                                            : 1'b0;

    // An empty-buffer reload at a word boundary only counts as an underrun once a bit of
    // that zero word is actually clocked, so a frame ending on a word boundary is clean.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hold_data        <= '0;
            hold_full        <= 1'b0;
            tx_shift         <= '0;
            rx_shift         <= '0;
            bit_cnt          <= 8'd0;
            sampled          <= 1'b0;
            pending_underrun <= 1'b0;
            tx_underrun      <= 1'b0;
            rx_data          <= '0;
            rx_bits          <= 8'd0;
            rx_valid         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end else if (reload) begin
                hold_full <= 1'b0;
            end

            if (do_sample) begin
                rx_shift <= rx_shifted;
                bit_cnt  <= bit_cnt + 8'd1;
                sampled  <= 1'b1;
                if (pending_underrun) begin
                    tx_underrun      <= 1'b1;
                    pending_underrun <= 1'b0;
                end
            end

            if (do_drive) tx_shift <= tx_shifted;

            if (reload) begin
                tx_shift <= hold_full ? hold_data : '0;
                sampled  <= 1'b0;
                if (start_frame) begin
                    pending_underrun <= 1'b0;
                    if (!hold_full) tx_underrun <= 1'b1;
                end else begin
                    pending_underrun <= !hold_full;
                end
            end

            if (report) begin
                rx_valid <= 1'b1;
                rx_bits  <= bit_cnt;
                rx_data  <= rx_aligned;
            end

            if (word_done || start_frame || end_frame) begin
                bit_cnt  <= 8'd0;
                rx_shift <= '0;
            end

            if (end_frame) begin
                sampled          <= 1'b0;
                pending_underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed-plus-random bench for spi_slave_responder: an SPI master model drives two
// slaves (default mode on ss bit 0, LSB-first/inverted edges on ss bit 3) sharing one bus.
module tb_spi_slave_responder;

    localparam int HALF = 4;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ss_pad = 8'hFF;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_valid0 = 1'b0;
    logic        tx_valid1 = 1'b0;

    logic        miso0, tx_ready0, rx_valid0, tx_underrun0, busy0;
    logic [31:0] rx_data0;
    logic [7:0]  rx_bits0;
    logic        miso1, tx_ready1, rx_valid1, tx_underrun1, busy1;
    logic [31:0] rx_data1;
    logic [7:0]  rx_bits1;

    int vectors = 0;
    int miscompares = 0;

    logic [39:0] rxq0[$];
    logic [39:0] rxq1[$];
    logic [31:0] txm0[$];
    logic [31:0] txm1[$];
    logic        exp_under0 = 1'b0;
    logic        exp_under1 = 1'b0;

    spi_slave_responder dut0 (
        .clock       (clock),
        .rst_n       (rst_n),
        .ss_pad_o    (ss_pad),
        .sclk        (sclk),
        .mosi_pad_o  (mosi),
        .miso_pad_i  (miso0),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid0),
        .tx_ready    (tx_ready0),
        .rx_data     (rx_data0),
        .rx_bits     (rx_bits0),
        .rx_valid    (rx_valid0),
        .tx_underrun (tx_underrun0),
        .busy        (busy0)
    );

    spi_slave_responder #(
        .DATA_W    (32),
        .SS_BIT    (3),
        .LSB_FIRST (1),
        .RX_NEG    (1),
        .TX_NEG    (0)
    ) dut1 (
        .clock       (clock),
        .rst_n       (rst_n),
        .ss_pad_o    (ss_pad),
        .sclk        (sclk),
        .mosi_pad_o  (mosi),
        .miso_pad_i  (miso1),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid1),
        .tx_ready    (tx_ready1),
        .rx_data     (rx_data1),
        .rx_bits     (rx_bits1),
        .rx_valid    (rx_valid1),
        .tx_underrun (tx_underrun1),
        .busy        (busy1)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_valid0 === 1'b1) rxq0.push_back({rx_bits0, rx_data0});
        if (rx_valid1 === 1'b1) rxq1.push_back({rx_bits1, rx_data1});
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Bit i of the result is the i-th bit on the wire for an n-bit word.
    function automatic logic [31:0] order_bits(input logic [31:0] w, input int n, input bit lsb);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < n; i++) o[i] = lsb ? w[i] : w[n-1-i];
        return o;
    endfunction

    function automatic logic [31:0] mask_n(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input bit sel, input logic [31:0] w);
        int n;
        n = 0;
        while (!(sel ? tx_ready1 : tx_ready0) && n < 500) begin
            @(negedge clock);
            n++;
        end
        check_output(sel ? "tx_ready1 wait" : "tx_ready0 wait", 64'(n < 500), 1);
        tx_data = w;
        if (sel) tx_valid1 = 1'b1; else tx_valid0 = 1'b1;
        @(negedge clock);
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
        if (sel) txm1.push_back(w); else txm0.push_back(w);
    endtask

    // Reference holding buffer: each word that starts transmitting takes the queued word or zeros.
    task automatic next_word(input bit sel, output logic [31:0] w);
        if (sel) begin
            if (txm1.size() > 0) w = txm1.pop_front();
            else begin w = '0; exp_under1 = 1'b1; end
        end else begin
            if (txm0.size() > 0) w = txm0.pop_front();
            else begin w = '0; exp_under0 = 1'b1; end
        end
    endtask

    task automatic expect_rx(input bit sel, input string tag, input logic [31:0] d, input logic [7:0] b);
        logic [39:0] e;
        int sz;
        sz = sel ? rxq1.size() : rxq0.size();
        check_output({tag, " present"}, 64'(sz > 0), 1);
        if (sz > 0) begin
            if (sel) e = rxq1.pop_front(); else e = rxq0.pop_front();
            check_output({tag, " data"}, 64'(e[31:0]), 64'(d));
            check_output({tag, " bits"}, 64'(e[39:32]), 64'(b));
        end
    endtask

    // sel=0: mode with sample on rise / drive on fall; sel=1: drive on rise / sample on fall.
    task automatic apply_stimulus(input bit sel, input int nbits, input logic [63:0] mosi_bits,
                                  input bit keep_ss, output logic [63:0] miso_bits);
        logic [7:0] mask;
        mask = sel ? 8'h08 : 8'h01;
        miso_bits = '0;
        @(negedge clock);
        ss_pad = ss_pad & ~mask;
        mosi = sel ? 1'b0 : mosi_bits[0];
        repeat (2*HALF) @(negedge clock);
        check_output(sel ? "busy1 in frame" : "busy0 in frame", 64'(sel ? busy1 : busy0), 1);
        for (int i = 0; i < nbits; i++) begin
            if (!sel) begin
                miso_bits[i] = miso0;
                sclk = 1'b1;
                repeat (HALF) @(negedge clock);
                sclk = 1'b0;
                if (i + 1 < nbits) mosi = mosi_bits[i+1];
                repeat (HALF) @(negedge clock);
            end else begin
                sclk = 1'b1;
                mosi = mosi_bits[i];
                repeat (HALF) @(negedge clock);
                miso_bits[i] = miso1;
                sclk = 1'b0;
                repeat (HALF) @(negedge clock);
            end
        end
        repeat (HALF) @(negedge clock);
        if (!keep_ss) ss_pad = ss_pad | mask;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        logic [63:0] mb;
        logic [31:0] w, w2, r, r2, eb;

        $display("[TB] reset");
        repeat (4) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check_output("reset miso", 64'(miso0), 0);
        check_output("reset tx_ready", 64'(tx_ready0), 1);
        check_output("reset rx_data", 64'(rx_data0), 0);
        check_output("reset rx_bits", 64'(rx_bits0), 0);
        check_output("reset rx_valid", 64'(rx_valid0), 0);
        check_output("reset underrun", 64'(tx_underrun0), 0);
        check_output("reset busy", 64'(busy0), 0);

        $display("[TB] single word MSB-first");
        push_tx(0, 32'hA5A5_0F0F);
        check_output("t1 tx_ready loaded", 64'(tx_ready0), 0);
        apply_stimulus(0, 32, {32'h0, order_bits(32'h1234_5678, 32, 0)}, 0, mb);
        next_word(0, w);
        eb = order_bits(w, 32, 0);
        check_output("t1 master read", mb, {32'h0, eb});
        check_output("t1 rx count", 64'(rxq0.size()), 1);
        expect_rx(0, "t1 rx", 32'h1234_5678, 8'd32);
        check_output("t1 underrun", 64'(tx_underrun0), 64'(exp_under0));
        check_output("t1 tx_ready", 64'(tx_ready0), 1);
        check_output("t1 busy idle", 64'(busy0), 0);

        $display("[TB] back-to-back words");
        r  = $urandom;
        r2 = $urandom;
        push_tx(0, 32'h1111_1111);
        check_output("t2 tx_ready full", 64'(tx_ready0), 0);
        fork
            apply_stimulus(0, 64, {order_bits(r2, 32, 0), order_bits(r, 32, 0)}, 0, mb);
            push_tx(0, 32'h2222_2222);
        join
        next_word(0, w);
        next_word(0, w2);
        eb = order_bits(w, 32, 0);
        check_output("t2 master word0", 64'(mb[31:0]), 64'(eb));
        eb = order_bits(w2, 32, 0);
        check_output("t2 master word1", 64'(mb[63:32]), 64'(eb));
        check_output("t2 rx count", 64'(rxq0.size()), 2);
        expect_rx(0, "t2 rx0", r, 8'd32);
        expect_rx(0, "t2 rx1", r2, 8'd32);
        check_output("t2 tx_ready", 64'(tx_ready0), 1);
        check_output("t2 underrun", 64'(tx_underrun0), 64'(exp_under0));

        $display("[TB] partial frame");
        push_tx(0, $urandom);
        apply_stimulus(0, 12, {32'h0, order_bits(32'h0000_0ABC, 12, 0)}, 0, mb);
        next_word(0, w);
        eb = order_bits(w, 32, 0) & mask_n(12);
        check_output("t3 master read", mb, {32'h0, eb});
        expect_rx(0, "t3 rx", 32'h0000_0ABC, 8'd12);
        check_output("t3 busy", 64'(busy0), 0);
        check_output("t3 underrun", 64'(tx_underrun0), 64'(exp_under0));

        $display("[TB] underrun");
        r = $urandom;
        apply_stimulus(0, 32, {32'h0, order_bits(r, 32, 0)}, 0, mb);
        next_word(0, w);
        eb = order_bits(w, 32, 0);
        check_output("t4 master read", mb, {32'h0, eb});
        expect_rx(0, "t4 rx", r, 8'd32);
        check_output("t4 underrun", 64'(tx_underrun0), 64'(exp_under0));
        push_tx(0, $urandom);
        r = $urandom;
        apply_stimulus(0, 32, {32'h0, order_bits(r, 32, 0)}, 0, mb);
        next_word(0, w);
        eb = order_bits(w, 32, 0);
        check_output("t4b master read", mb, {32'h0, eb});
        expect_rx(0, "t4b rx", r, 8'd32);
        check_output("t4b underrun sticky", 64'(tx_underrun0), 64'(exp_under0));

        $display("[TB] LSB-first slave on ss bit 3");
        push_tx(1, $urandom);
        apply_stimulus(1, 32, {32'h0, order_bits(32'h0000_00C3, 32, 1)}, 0, mb);
        next_word(1, w);
        eb = order_bits(w, 32, 1);
        check_output("t5 master read", mb, {32'h0, eb});
        expect_rx(1, "t5 rx", 32'h0000_00C3, 8'd32);
        check_output("t5 underrun", 64'(tx_underrun1), 64'(exp_under1));
        push_tx(1, $urandom);
        r = $urandom;
        apply_stimulus(1, 8, {32'h0, order_bits(r, 8, 1)}, 0, mb);
        next_word(1, w);
        eb = order_bits(w, 32, 1) & mask_n(8);
        check_output("t5b master read", mb, {32'h0, eb});
        expect_rx(1, "t5b rx", r & mask_n(8), 8'd8);
        check_output("t5 dut0 ignores", 64'(rxq0.size()), 0);
        check_output("t5 dut0 idle", 64'(busy0), 0);

        $display("[TB] reset mid-frame");
        apply_stimulus(0, 10, {32'h0, order_bits($urandom, 10, 0)}, 1, mb);
        check_output("t6 busy before abort", 64'(busy0), 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clock);
        ss_pad = 8'hFF;
        rst_n = 1'b1;
        txm0.delete();
        txm1.delete();
        exp_under0 = 1'b0;
        exp_under1 = 1'b0;
        repeat (4) @(negedge clock);
        check_output("t6 busy after reset", 64'(busy0), 0);
        check_output("t6 underrun cleared", 64'(tx_underrun0), 0);
        check_output("t6 tx_ready", 64'(tx_ready0), 1);
        check_output("t6 miso", 64'(miso0), 0);
        check_output("t6 aborted no rx", 64'(rxq0.size()), 0);
        push_tx(0, $urandom);
        apply_stimulus(0, 32, {32'h0, order_bits(32'hDEAD_BEEF, 32, 0)}, 0, mb);
        next_word(0, w);
        eb = order_bits(w, 32, 0);
        check_output("t6 master read", mb, {32'h0, eb});
        check_output("t6 rx count", 64'(rxq0.size()), 1);
        expect_rx(0, "t6 rx", 32'hDEAD_BEEF, 8'd32);
        check_output("t6 underrun", 64'(tx_underrun0), 64'(exp_under0));
        check_output("t6 dut1 no rx", 64'(rxq1.size()), 0);
        check_output("t6 dut1 idle", 64'(busy1), 0);
        check_output("t6 dut1 underrun", 64'(tx_underrun1), 64'(exp_under1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
